// File: rtl/autotype_sequencer.sv
// -----------------------------------------------------------------------------
// autotype_sequencer
//
// Power-on key sequencer and button front-end. After reset it holds the
// computer core in reset, then "types" a table of key masks (one mask per
// step, released between presses), and finally passes debounced physical
// buttons straight through to the core's key lines.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   restart      one-cycle pulse; restarts the whole sequence from RESET_HOLD
//   btn          raw active-high key buttons (one per channel)
//   btn_reset    raw active-high manual reset button
//   n_reset_out  active-low reset to the computer core
//   keys         active-high key lines to the core
//   busy         high while holding reset or typing (RESET_HOLD/GAP/PRESS)
//   step_idx     index of the current sequence step
// -----------------------------------------------------------------------------
module autotype_sequencer #(
    parameter int unit_clocks     = 25000,
    parameter int channels        = 4,
    parameter int steps           = 8,
    parameter logic [steps*channels-1:0] key_sequence = 32'h00011142,
    parameter int reset_units     = 300,
    parameter int gap_units       = 200,
    parameter int press_units     = 100,
    parameter int debounce_units  = 10,
    parameter int abort_on_button = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         restart,
    input  logic [channels-1:0]          btn,
    input  logic                         btn_reset,
    output logic                         n_reset_out,
    output logic [channels-1:0]          keys,
    output logic                         busy,
    output logic [$clog2(steps+1)-1:0]   step_idx
);

    localparam int step_w    = $clog2(steps + 1);
    // A duration of zero units behaves as one unit.
    localparam int reset_n   = (reset_units    < 1) ? 1 : reset_units;
    localparam int gap_n     = (gap_units      < 1) ? 1 : gap_units;
    localparam int press_n   = (press_units    < 1) ? 1 : press_units;
    localparam int deb_n     = (debounce_units < 1) ? 1 : debounce_units;
    localparam int max_units = (reset_n > gap_n) ? ((reset_n > press_n) ? reset_n : press_n)
                                                 : ((gap_n   > press_n) ? gap_n   : press_n);
    localparam int unit_w    = $clog2(max_units + 1);
    localparam int pre_w     = (unit_clocks > 1) ? $clog2(unit_clocks) : 1;
    localparam int db_cycles = deb_n * unit_clocks;
    localparam int db_w      = (db_cycles > 1) ? $clog2(db_cycles) : 1;
    // Debounced inputs: bits [channels-1:0] are the keys, bit [channels] is btn_reset.
    localparam int nb        = channels + 1;

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        GAP        = 2'd1,
        PRESS      = 2'd2,
        DONE       = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and debouncers
    // ------------------------------------------------------------------
    logic [nb-1:0] raw_all;
    logic [nb-1:0] sync1_reg;
    logic [nb-1:0] sync2_reg;
    logic [nb-1:0] db_reg;
    logic [nb-1:0] db_next;

    assign raw_all = {btn_reset, btn};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            db_reg    <= '0;
        end else begin
            sync1_reg <= raw_all;
            sync2_reg <= sync1_reg;
            db_reg    <= db_next;
        end
    end

    generate
        for (genvar gi = 0; gi < nb; gi++) begin : g_debounce
            logic [db_w-1:0] cnt_reg;
            logic            differs;
            logic            cnt_full;

            assign differs  = (sync2_reg[gi] != db_reg[gi]);
            assign cnt_full = (cnt_reg == db_w'(db_cycles - 1));
            // The debounced value only follows the synchronised input once it
            // has disagreed for db_cycles consecutive clocks.
            assign db_next[gi] = (differs && cnt_full) ? sync2_reg[gi] : db_reg[gi];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (!differs || cnt_full) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + db_w'(1);
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Key mask table
    // ------------------------------------------------------------------
    logic [channels-1:0] mask_tab [steps];

    generate
        for (genvar gi = 0; gi < steps; gi++) begin : g_mask
            assign mask_tab[gi] = key_sequence[gi*channels +: channels];
        end
    endgenerate

    // Step index may equal steps (past the table); that reads as an empty mask.
    function automatic logic [channels-1:0] mask_of(input logic [step_w-1:0] s);
        logic [channels-1:0] m;
        m = '0;
        for (int i = 0; i < steps; i++) begin
            if (s == step_w'(i)) begin
                m = mask_tab[i];
            end
        end
        return m;
    endfunction

    // ------------------------------------------------------------------
    // Sequencer state, timers and registered outputs
    // ------------------------------------------------------------------
    state_t              state_reg, state_next;
    logic [step_w-1:0]   step_reg, step_next;
    logic [pre_w-1:0]    pre_reg, pre_next;
    logic [unit_w-1:0]   unit_reg, unit_next;
    logic                n_reset_reg, n_reset_next;
    logic [channels-1:0] keys_reg, keys_next;
    logic                busy_reg, busy_next;

    logic [channels-1:0] btn_db_next;
    logic                brst_db_next;
    logic                key_rise;
    logic [unit_w-1:0]   cur_units;
    logic                expire;
    logic                clear_timer;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= RESET_HOLD;
            step_reg    <= '0;
            pre_reg     <= '0;
            unit_reg    <= '0;
            n_reset_reg <= 1'b0;
            keys_reg    <= '0;
            busy_reg    <= 1'b1;
        end else begin
            state_reg   <= state_next;
            step_reg    <= step_next;
            pre_reg     <= pre_next;
            unit_reg    <= unit_next;
            n_reset_reg <= n_reset_next;
            keys_reg    <= keys_next;
            busy_reg    <= busy_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        step_next    = step_reg;
        pre_next     = pre_reg;
        unit_next    = unit_reg;
        n_reset_next = 1'b1;
        keys_next    = '0;
        busy_next    = 1'b1;
        cur_units    = unit_w'(1);
        clear_timer  = 1'b0;

        // Debounced values as they will be after this edge, so the outputs
        // and the abort decision react in the same cycle the debouncer flips.
        btn_db_next  = db_next[channels-1:0];
        brst_db_next = db_next[channels];
        key_rise     = |(btn_db_next & ~db_reg[channels-1:0]);

        case (state_reg)
            RESET_HOLD: cur_units = unit_w'(reset_n);
            GAP:        cur_units = unit_w'(gap_n);
            PRESS:      cur_units = unit_w'(press_n);
            default:    cur_units = unit_w'(1);
        endcase

        expire = (pre_reg == pre_w'(unit_clocks - 1)) && (unit_reg == cur_units - unit_w'(1));

        if (brst_db_next) begin
            state_next = DONE;
        end else if (restart) begin
            state_next  = RESET_HOLD;
            step_next   = '0;
            clear_timer = 1'b1;
        end else if ((abort_on_button != 0) && key_rise &&
                     ((state_reg == GAP) || (state_reg == PRESS))) begin
            state_next = DONE;
        end else if (expire) begin
            case (state_reg)
                RESET_HOLD: begin
                    state_next = GAP;
                    step_next  = '0;
                end
                GAP: begin
                    if ((step_reg == step_w'(steps)) || (mask_of(step_reg) == '0)) begin
                        state_next = DONE;
                    end else begin
                        state_next = PRESS;
                    end
                end
                PRESS: begin
                    state_next = GAP;
                    step_next  = step_reg + step_w'(1);
                end
                default: state_next = DONE;
            endcase
        end

        // Prescaler and unit counter restart on every state change; DONE is untimed.
        if (clear_timer || (state_next != state_reg) || (state_reg == DONE)) begin
            pre_next  = '0;
            unit_next = '0;
        end else if (pre_reg == pre_w'(unit_clocks - 1)) begin
            pre_next  = '0;
            unit_next = unit_reg + unit_w'(1);
        end else begin
            pre_next  = pre_reg + pre_w'(1);
        end

        // Outputs follow the next state so they change on the transition edge.
        busy_next    = (state_next != DONE);
        n_reset_next = !brst_db_next && (state_next != RESET_HOLD);
        if (brst_db_next) begin
            keys_next = '0;
        end else if (state_next == PRESS) begin
            keys_next = mask_of(step_next) | btn_db_next;
        end else begin
            keys_next = btn_db_next;
        end
    end

    assign n_reset_out = n_reset_reg;
    assign keys        = keys_reg;
    assign busy        = busy_reg;
    assign step_idx    = step_reg;

endmodule

// File: tb/tb_autotype_sequencer.sv
// -----------------------------------------------------------------------------
// tb_autotype_sequencer
//
// Directed bench for autotype_sequencer with unit_clocks=4, reset_units=3,
// gap_units=2, press_units=1, debounce_units=2. Three instances share clock,
// reset and restart:
//   dut_a  default sequence, abort enabled
//   dut_n  default sequence, abort disabled, btn[0] held
//   dut_f  all eight masks nonzero (8'h1,2,4,8 repeated)
// Cycle k is sampled on the falling edge just before rising edge k; inputs are
// changed at the same falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_autotype_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       restart = 1'b0;
    logic [3:0] btn_a = 4'b0000, btn_n = 4'b0001, btn_f = 4'b0000;
    logic       brst_a = 1'b0, brst_n = 1'b0, brst_f = 1'b0;
    logic       nr_a, nr_n, nr_f;
    logic [3:0] keys_a, keys_n, keys_f;
    logic       busy_a, busy_n, busy_f;
    logic [3:0] step_a, step_n, step_f;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    autotype_sequencer #(
        .unit_clocks(4), .channels(4), .steps(8), .key_sequence(32'h00011142),
        .reset_units(3), .gap_units(2), .press_units(1), .debounce_units(2),
        .abort_on_button(1)
    ) dut_a (
        .clk(clk), .reset(reset), .restart(restart), .btn(btn_a), .btn_reset(brst_a),
        .n_reset_out(nr_a), .keys(keys_a), .busy(busy_a), .step_idx(step_a)
    );

    autotype_sequencer #(
        .unit_clocks(4), .channels(4), .steps(8), .key_sequence(32'h00011142),
        .reset_units(3), .gap_units(2), .press_units(1), .debounce_units(2),
        .abort_on_button(0)
    ) dut_n (
        .clk(clk), .reset(reset), .restart(restart), .btn(btn_n), .btn_reset(brst_n),
        .n_reset_out(nr_n), .keys(keys_n), .busy(busy_n), .step_idx(step_n)
    );

    autotype_sequencer #(
        .unit_clocks(4), .channels(4), .steps(8), .key_sequence(32'h84218421),
        .reset_units(3), .gap_units(2), .press_units(1), .debounce_units(2),
        .abort_on_button(1)
    ) dut_f (
        .clk(clk), .reset(reset), .restart(restart), .btn(btn_f), .btn_reset(brst_f),
        .n_reset_out(nr_f), .keys(keys_f), .busy(busy_f), .step_idx(step_f)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
    endtask

    // Default sequence: B at 20-23, C at 32-35, ENTER at 44-47, 56-59, 68-71.
    function automatic logic [3:0] exp_keys_def(input int c);
        if (c >= 20 && c <= 23) return 4'b0010;
        if (c >= 32 && c <= 35) return 4'b0100;
        if ((c >= 44 && c <= 47) || (c >= 56 && c <= 59) || (c >= 68 && c <= 71)) return 4'b0001;
        return 4'b0000;
    endfunction

    function automatic logic [3:0] exp_step_def(input int c);
        if (c >= 72) return 4'd5;
        if (c >= 60) return 4'd4;
        if (c >= 48) return 4'd3;
        if (c >= 36) return 4'd2;
        if (c >= 24) return 4'd1;
        return 4'd0;
    endfunction

    // Full table: press i at 20+12i .. 23+12i, masks 1,2,4,8,1,2,4,8.
    function automatic logic [3:0] exp_keys_full(input int c);
        for (int i = 0; i < 8; i++) begin
            if (c >= 20 + 12*i && c <= 23 + 12*i) return 4'b0001 << (i % 4);
        end
        return 4'b0000;
    endfunction

    function automatic logic [3:0] exp_step_full(input int c);
        if (c < 24) return 4'd0;
        if (c >= 108) return 4'd8;
        return 4'((c - 12) / 12);
    endfunction

    task automatic run_timeline(input int n, input bit full);
        for (int i = 0; i < n; i++) begin
            check_val("a_n_reset", 32'(nr_a), 32'(cyc >= 12));
            check_val("a_busy", 32'(busy_a), 32'(cyc < 80));
            check_val("a_keys", 32'(keys_a), 32'(exp_keys_def(cyc)));
            check_val("a_step", 32'(step_a), 32'(exp_step_def(cyc)));
            if (full) begin
                check_val("n_keys", 32'(keys_n), 32'(exp_keys_def(cyc) | ((cyc >= 10) ? 4'b0001 : 4'b0000)));
                check_val("n_busy", 32'(busy_n), 32'(cyc < 80));
                check_val("n_step", 32'(step_n), 32'(exp_step_def(cyc)));
                check_val("f_n_reset", 32'(nr_f), 32'(cyc >= 12));
                check_val("f_keys", 32'(keys_f), 32'(exp_keys_full(cyc)));
                check_val("f_busy", 32'(busy_f), 32'(cyc < 116));
                check_val("f_step", 32'(step_f), 32'(exp_step_full(cyc)));
            end
            next_cycle();
        end
    endtask

    initial begin
        // Power-on timeline on all three instances.
        do_reset();
        run_timeline(130, 1'b1);
        $display("power-on sequence: checks=%0d errors=%0d", checks, errors);

        // Restart pulse while dut_a is in DONE; timeline repeats.
        restart = 1'b1;
        next_cycle();
        restart = 1'b0;
        cyc = 0;
        run_timeline(26, 1'b0);
        $display("restart from DONE: checks=%0d errors=%0d", checks, errors);

        // Asynchronous reset mid-GAP (step 1): outputs return without a clock edge.
        #2 reset = 1'b1;
        #1;
        check_val("async_n_reset", 32'(nr_a), 32'd0);
        check_val("async_busy", 32'(busy_a), 32'd1);
        check_val("async_keys", 32'(keys_a), 32'd0);
        check_val("async_step", 32'(step_a), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        run_timeline(90, 1'b0);
        $display("async reset mid-GAP: checks=%0d errors=%0d", checks, errors);

        // Five-cycle glitch on btn[3] is rejected; sequence unaffected.
        do_reset();
        for (int i = 0; i < 90; i++) begin
            btn_a[3] = (cyc >= 25 && cyc < 30);
            check_val("glitch_keys", 32'(keys_a), 32'(exp_keys_def(cyc)));
            check_val("glitch_busy", 32'(busy_a), 32'(cyc < 80));
            next_cycle();
        end
        btn_a = 4'b0000;
        $display("btn glitch rejected: checks=%0d errors=%0d", checks, errors);

        // Held btn[3] from cycle 25 aborts at cycle 35 during the C press.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            btn_a[3] = (cyc >= 25);
            check_val("abort_keys", 32'(keys_a), 32'((cyc < 35) ? exp_keys_def(cyc) : 4'b1000));
            check_val("abort_busy", 32'(busy_a), 32'(cyc < 35));
            check_val("abort_step", 32'(step_a), 32'((cyc < 35) ? exp_step_def(cyc) : 4'd1));
            next_cycle();
        end
        btn_a = 4'b0000;
        $display("button abort: checks=%0d errors=%0d", checks, errors);

        // Manual reset pressed at 30, released at 50.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            brst_a = (cyc >= 30 && cyc < 50);
            if (cyc < 40) begin
                check_val("man_n_reset", 32'(nr_a), 32'(cyc >= 12));
                check_val("man_keys", 32'(keys_a), 32'(exp_keys_def(cyc)));
                check_val("man_busy", 32'(busy_a), 32'd1);
            end else begin
                check_val("man_n_reset", 32'(nr_a), 32'(cyc >= 60));
                check_val("man_keys", 32'(keys_a), 32'd0);
                check_val("man_busy", 32'(busy_a), 32'd0);
                check_val("man_step", 32'(step_a), 32'd2);
            end
            next_cycle();
        end
        brst_a = 1'b0;
        $display("manual reset: checks=%0d errors=%0d", checks, errors);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
